// File: rtl/sd_spi_pkg.sv
// Shared types and protocol constants for the SPI-mode SD host.
package sd_spi_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_RESP,
        ST_RD_TOKEN,
        ST_RD_DATA,
        ST_RD_CRC,
        ST_WR_GAP,
        ST_WR_TOKEN,
        ST_WR_DATA,
        ST_WR_CRC,
        ST_WR_DRESP,
        ST_WR_BUSY,
        ST_DONE
    } state_t;

    localparam logic [5:0]  CMD_READ    = 6'd17;
    localparam logic [5:0]  CMD_WRITE   = 6'd24;
    localparam logic [7:0]  START_TOKEN = 8'hFE;
    localparam logic [4:0]  DRESP_OK    = 5'b00101;
    localparam logic [6:0]  CRC7_POLY   = 7'h09;
    localparam logic [15:0] CRC16_POLY  = 16'h1021;

endpackage

// File: rtl/sd_crc_serial.sv
// Bit-serial MSB-first CRC register, zero init; clr has priority over en.
module sd_crc_serial #(
    parameter int unsigned      WIDTH = 7,
    parameter logic [WIDTH-1:0] POLY  = 7'h09
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] crc
);

    logic [WIDTH-1:0] r_crc;
    logic             w_fb;

    assign w_fb = r_crc[WIDTH-1] ^ din;
    assign crc  = r_crc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc <= '0;
        end else if (clr) begin
            r_crc <= '0;
        end else if (en) begin
            r_crc <= {r_crc[WIDTH-2:0], 1'b0} ^ (w_fb ? POLY : '0);
        end
    end

endmodule

// File: rtl/sd_spi_host.sv
// SPI-mode SD host: one CMD17/CMD24 single-block transfer per request,
// CRC7 on the command, CRC16 on the 64-bit data block.
module sd_spi_host
    import sd_spi_pkg::*;
#(
    parameter int unsigned GAP_BYTES = 1,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        in_write,
    input  logic [15:0] in_addr,
    input  logic [63:0] in_wdata,
    output logic        busy,
    output logic        out_valid,
    output logic [63:0] out_rdata,
    output logic        out_err,
    input  logic        MISO,
    output logic        MOSI
);

    localparam int unsigned TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    // The RESP->WR_GAP edge already yields one high cycle, and the token's
    // seven leading ones follow, so the gap state itself runs 8*GAP-1 edges.
    localparam logic [8:0]  GAP_LAST = 9'(8 * GAP_BYTES - 2);

    state_t          r_state, w_state;
    logic [8:0]      r_cnt, w_cnt;
    logic [TO_W-1:0] r_to, w_to;
    logic [39:0]     r_frame, w_frame;
    logic            r_write, w_write;
    logic [63:0]     r_data, w_data;
    logic [14:0]     r_sh, w_sh;
    logic [63:0]     r_rdata, w_rdata;
    logic            r_err, w_err;
    logic            r_mosi, w_mosi;

    logic            w_crc_clr, w_c7_en, w_c7_din, w_c16_en, w_c16_din;
    logic [6:0]      w_crc7;
    logic [15:0]     w_crc16;
    logic [7:0]      w_miso_byte;
    logic [15:0]     w_miso_crc;
    logic            w_to_hit;
    logic            w_frame_bit, w_crc7_bit;

    assign w_miso_byte = {r_sh[6:0], MISO};
    assign w_miso_crc  = {r_sh, MISO};
    assign w_to_hit    = (r_to == TO_LAST);
    assign w_frame_bit = r_frame[6'(9'd39 - r_cnt)];
    assign w_crc7_bit  = w_crc7[3'(9'd46 - r_cnt)];

    sd_crc_serial #(.WIDTH(7), .POLY(CRC7_POLY)) u_crc7 (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (w_crc_clr),
        .en   (w_c7_en),
        .din  (w_c7_din),
        .crc  (w_crc7)
    );

    sd_crc_serial #(.WIDTH(16), .POLY(CRC16_POLY)) u_crc16 (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (w_crc_clr),
        .en   (w_c16_en),
        .din  (w_c16_din),
        .crc  (w_crc16)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_to    <= '0;
            r_frame <= '0;
            r_write <= 1'b0;
            r_data  <= '0;
            r_sh    <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_mosi  <= 1'b1;
        end else begin
            r_cnt   <= w_cnt;
            r_to    <= w_to;
            r_frame <= w_frame;
            r_write <= w_write;
            r_data  <= w_data;
            r_sh    <= w_sh;
            r_rdata <= w_rdata;
            r_err   <= w_err;
            r_mosi  <= w_mosi;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_to      = r_to;
        w_frame   = r_frame;
        w_write   = r_write;
        w_data    = r_data;
        w_sh      = r_sh;
        w_rdata   = r_rdata;
        w_err     = r_err;
        w_mosi    = 1'b1;
        w_crc_clr = 1'b0;
        w_c7_en   = 1'b0;
        w_c7_din  = 1'b0;
        w_c16_en  = 1'b0;
        w_c16_din = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                w_crc_clr = 1'b1;
                w_err     = 1'b0;
                w_cnt     = '0;
                if (in_valid) begin
                    // Leading '0' goes out on the accept edge; it leaves a zero CRC7 unchanged.
                    w_write = in_write;
                    w_frame = {2'b01, (in_write ? CMD_WRITE : CMD_READ), 16'h0000, in_addr};
                    w_data  = in_wdata;
                    w_mosi  = 1'b0;
                    w_cnt   = 9'd1;
                    w_state = ST_CMD;
                end
            end
            ST_CMD: begin
                if (r_cnt <= 9'd39) begin
                    w_mosi   = w_frame_bit;
                    w_c7_en  = 1'b1;
                    w_c7_din = w_frame_bit;
                end else if (r_cnt <= 9'd46) begin
                    w_mosi = w_crc7_bit;
                end
                w_cnt = r_cnt + 9'd1;
                if (r_cnt == 9'd47) begin
                    w_cnt   = '0;
                    w_to    = '0;
                    w_state = ST_RESP;
                end
            end
            ST_RESP, ST_WR_DRESP: begin
                if (r_cnt == 9'd0) begin
                    if (!MISO) begin
                        w_sh  = {r_sh[13:0], MISO};
                        w_cnt = 9'd1;
                    end else if (w_to_hit) begin
                        w_err   = 1'b1;
                        w_state = ST_DONE;
                    end else begin
                        w_to = r_to + 1'b1;
                    end
                end else begin
                    w_sh  = {r_sh[13:0], MISO};
                    w_cnt = r_cnt + 9'd1;
                    if (r_cnt == 9'd7) begin
                        w_cnt = '0;
                        w_to  = '0;
                        if (r_state == ST_RESP) begin
                            if (w_miso_byte == 8'h00) begin
                                w_state = r_write ? ST_WR_GAP : ST_RD_TOKEN;
                            end else begin
                                w_err   = 1'b1;
                                w_state = ST_DONE;
                            end
                        end else if (w_miso_byte[4:0] == DRESP_OK) begin
                            w_state = ST_WR_BUSY;
                        end else begin
                            w_err   = 1'b1;
                            w_state = ST_DONE;
                        end
                    end
                end
            end
            ST_RD_TOKEN: begin
                if (!MISO) begin
                    w_cnt   = '0;
                    w_state = ST_RD_DATA;
                end else if (w_to_hit) begin
                    w_err   = 1'b1;
                    w_state = ST_DONE;
                end else begin
                    w_to = r_to + 1'b1;
                end
            end
            ST_RD_DATA: begin
                w_data    = {r_data[62:0], MISO};
                w_c16_en  = 1'b1;
                w_c16_din = MISO;
                w_cnt     = r_cnt + 9'd1;
                if (r_cnt == 9'd63) begin
                    w_cnt   = '0;
                    w_state = ST_RD_CRC;
                end
            end
            ST_RD_CRC: begin
                w_sh  = {r_sh[13:0], MISO};
                w_cnt = r_cnt + 9'd1;
                if (r_cnt == 9'd15) begin
                    if (w_miso_crc == w_crc16) begin
                        w_rdata = r_data;
                    end else begin
                        w_err = 1'b1;
                    end
                    w_state = ST_DONE;
                end
            end
            ST_WR_GAP: begin
                w_cnt = r_cnt + 9'd1;
                if (r_cnt == GAP_LAST) begin
                    w_cnt   = '0;
                    w_state = ST_WR_TOKEN;
                end
            end
            ST_WR_TOKEN: begin
                w_mosi = START_TOKEN[~r_cnt[2:0]];
                w_cnt  = r_cnt + 9'd1;
                if (r_cnt == 9'd7) begin
                    w_cnt   = '0;
                    w_state = ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                w_mosi    = r_data[63];
                w_data    = {r_data[62:0], 1'b0};
                w_c16_en  = 1'b1;
                w_c16_din = r_data[63];
                w_cnt     = r_cnt + 9'd1;
                if (r_cnt == 9'd63) begin
                    w_cnt   = '0;
                    w_state = ST_WR_CRC;
                end
            end
            ST_WR_CRC: begin
                w_mosi = w_crc16[~r_cnt[3:0]];
                w_cnt  = r_cnt + 9'd1;
                if (r_cnt == 9'd15) begin
                    w_cnt   = '0;
                    w_to    = '0;
                    w_state = ST_WR_DRESP;
                end
            end
            ST_WR_BUSY: begin
                if (MISO) begin
                    w_state = ST_DONE;
                end else if (w_to_hit) begin
                    w_err   = 1'b1;
                    w_state = ST_DONE;
                end else begin
                    w_to = r_to + 1'b1;
                end
            end
            ST_DONE: begin
                w_state = ST_IDLE;
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    assign MOSI      = r_mosi;
    assign busy      = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign out_valid = (r_state == ST_DONE);
    assign out_err   = r_err;
    assign out_rdata = r_rdata;

endmodule

// File: tb/tb_sd_spi_host.sv
// Directed bench for sd_spi_host with a behavioural SD card on MISO/MOSI.
module tb_sd_spi_host;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_write;
    logic [15:0] in_addr;
    logic [63:0] in_wdata;
    logic        busy;
    logic        out_valid;
    logic [63:0] out_rdata;
    logic        out_err;
    logic        MISO;
    logic        MOSI;

    int          checks;
    int          failures;
    logic [63:0] exp_rdata;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [63:0] data;
        logic [7:0]  resp;
        logic [7:0]  dresp;
        logic        crc_bad;
        logic        exp_err;
    } vec_t;

    vec_t vecs [7];

    sd_spi_host #(.GAP_BYTES(1), .TIMEOUT(64)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_write (in_write),
        .in_addr  (in_addr),
        .in_wdata (in_wdata),
        .busy     (busy),
        .out_valid(out_valid),
        .out_rdata(out_rdata),
        .out_err  (out_err),
        .MISO     (MISO),
        .MOSI     (MOSI)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = c[6] ^ d[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [15:0] crc16(input logic [63:0] d);
        logic [15:0] c;
        logic        fb;
        c = '0;
        for (int i = 63; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    function automatic logic [47:0] exp_frame(input logic wr, input logic [15:0] addr);
        logic [39:0] head;
        head = {2'b01, (wr ? 6'd24 : 6'd17), 16'h0000, addr};
        return {head, crc7(head), 1'b1};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            MISO = b[i];
            @(negedge clk);
        end
    endtask

    // Issue a request and capture the 48-bit command frame; ends one cycle after the end bit.
    task automatic request(input logic wr, input logic [15:0] addr, input logic [63:0] wdata,
                           output logic [47:0] frame);
        in_valid = 1'b1;
        in_write = wr;
        in_addr  = addr;
        in_wdata = wdata;
        @(negedge clk);
        in_valid = 1'b0;
        chk("busy_accept", {63'd0, busy}, 64'd1);
        frame = '0;
        for (int i = 0; i < 48; i++) begin
            frame = {frame[46:0], MOSI};
            @(negedge clk);
        end
    endtask

    task automatic count_gap(output int n);
        n = 0;
        while (MOSI === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_txn(input vec_t v);
        logic [47:0] frame;
        logic [63:0] got;
        logic [15:0] gcrc;
        logic [15:0] ccrc;
        int          n;
        request(v.wr, v.addr, v.wr ? v.data : 64'h5555_AAAA_5555_AAAA, frame);
        chk("cmd_frame", frame, {16'd0, exp_frame(v.wr, v.addr)});
        if (!v.wr && v.addr == 16'h0000)
            chk("cmd17_addr0", frame, 64'h0000_5100_0000_0055);
        drive_byte(v.resp);
        MISO = 1'b1;
        if (v.resp != 8'h00) begin
            // error response: completion expected right away
        end else if (!v.wr) begin
            drive_byte(8'hFE);
            for (int i = 63; i >= 0; i--) begin
                MISO = v.data[i];
                @(negedge clk);
            end
            ccrc = crc16(v.data) ^ (v.crc_bad ? 16'h0400 : 16'h0000);
            for (int i = 15; i >= 0; i--) begin
                MISO = ccrc[i];
                @(negedge clk);
            end
            MISO = 1'b1;
        end else begin
            count_gap(n);
            chk("gap_high_cycles", 64'(n), 64'd15);
            got = '0;
            for (int i = 0; i < 64; i++) begin
                @(negedge clk);
                got = {got[62:0], MOSI};
            end
            gcrc = '0;
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                gcrc = {gcrc[14:0], MOSI};
            end
            chk("wr_data", got, v.data);
            chk("wr_crc16", {48'd0, gcrc}, {48'd0, crc16(v.data)});
            drive_byte(v.dresp);
            MISO = 1'b1;
            if (v.dresp[4:0] == 5'b00101) begin
                for (int i = 0; i < 8; i++) begin
                    MISO = 1'b0;
                    @(negedge clk);
                end
                MISO = 1'b1;
                chk("busy_hold", {62'd0, out_valid, busy}, 64'd1);
                @(negedge clk);
            end
        end
        if (!v.wr && !v.exp_err) exp_rdata = v.data;
        chk("out_valid", {63'd0, out_valid}, 64'd1);
        chk("out_err", {63'd0, out_err}, {63'd0, v.exp_err});
        chk("out_rdata", out_rdata, exp_rdata);
        chk("busy_done", {63'd0, busy}, 64'd0);
        @(negedge clk);
        chk("out_valid_pulse", {63'd0, out_valid}, 64'd0);
        chk("mosi_idle", {63'd0, MOSI}, 64'd1);
    endtask

    initial begin
        logic [47:0] frame;
        logic [63:0] dummy;
        int          n;
        int          bad;

        checks    = 0;
        failures  = 0;
        exp_rdata = '0;

        vecs[0] = '{1'b0, 16'h0000, 64'h0123_4567_89AB_CDEF, 8'h00, 8'h05, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 16'hFFFF, 64'hDEAD_BEEF_CAFE_F00D, 8'h00, 8'h05, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 16'h1234, 64'hA5A5_5A5A_0F0F_F0F0, 8'h00, 8'h05, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 16'h0042, 64'h1111_2222_3333_4444, 8'h00, 8'h0B, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 16'hBEEF, 64'h7777_7777_7777_7777, 8'h04, 8'h05, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 16'h00FF, 64'hFFFF_0000_8001_7FFE, 8'h00, 8'h05, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 16'h0001, 64'h0000_0000_0000_0001, 8'h00, 8'h05, 1'b0, 1'b0};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_write = 1'b0;
        in_addr  = '0;
        in_wdata = '0;
        MISO     = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mosi", {63'd0, MOSI}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_err", {63'd0, out_err}, 64'd0);
        chk("rst_out_rdata", out_rdata, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i]);
        end

        // Card silent: completion 64 cycles after the end bit; a request during busy is dropped.
        request(1'b0, 16'h0007, 64'h0, frame);
        chk("cmd_frame_to", {16'd0, frame}, {16'd0, exp_frame(1'b0, 16'h0007)});
        n = 48;
        in_valid = 1'b1;
        in_write = 1'b1;
        @(negedge clk);
        n++;
        in_valid = 1'b0;
        while (!out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycle", 64'(n), 64'd111);
        chk("timeout_err", {63'd0, out_err}, 64'd1);
        chk("timeout_rdata", out_rdata, exp_rdata);
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy !== 1'b0 || MOSI !== 1'b1) bad++;
            @(negedge clk);
        end
        chk("ignored_request", 64'(bad), 64'd0);

        // Reset in the middle of the write data phase.
        request(1'b1, 16'h0300, 64'hFEDC_BA98_7654_3210, frame);
        drive_byte(8'h00);
        MISO = 1'b1;
        count_gap(n);
        chk("gap_high_cycles_rst", 64'(n), 64'd15);
        dummy = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            dummy = {dummy[62:0], MOSI};
        end
        chk("wr_data_first30", {34'd0, dummy[29:0]}, {34'd0, 30'(64'hFEDC_BA98_7654_3210 >> 34)});
        rst_n = 1'b0;
        #1;
        chk("abort_mosi", {63'd0, MOSI}, 64'd1);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_rdata = '0;
        @(negedge clk);
        chk("abort_rdata", out_rdata, exp_rdata);
        run_txn(vecs[5]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
